// File: rtl/sm_trace_buffer.sv
// -----------------------------------------------------------------------------
// sm_trace_buffer
//
// Instruction-trace capture block that sits beside the CPU. Each cycle with
// cpuEn=1 it can record {pc, instr, v0, stamp} into a circular buffer. Capture
// starts on an arm pulse and freezes when the PC matches trigPc (followed by
// POST_TRIG further samples) or when TIMEOUT samples pass without a trigger.
// The frozen window can then be read out through an indexed port, where index 0
// is the oldest captured entry.
//
// Ports:
//   clk        CPU clock
//   rst        asynchronous active-high reset
//   cpuEn      sample qualifier; nothing moves in cycles with cpuEn=0
//   pc/instr/v0  per-cycle trace data from the CPU
//   arm        pulse: clear the window and start a new capture (highest priority)
//   trigPc     PC value that triggers the freeze
//   trigEn     1 = freeze on pc==trigPc, 0 = freeze only on timeout
//   rdIdx      readout index, 0 = oldest captured entry
//   rdPc/rdInstr/rdV0/rdStamp  registered readout of the selected entry
//   rdValid    registered: done && rdIdx < count
//   count      number of valid entries, saturates at DEPTH
//   triggered  trigger seen in the current run
//   timedOut   current run ended by timeout
//   done       capture frozen, buffer readable
// -----------------------------------------------------------------------------
module sm_trace_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned POST_TRIG  = 4,
    parameter int unsigned TIMEOUT    = 120
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpuEn,
    input  logic [31:0]           pc,
    input  logic [31:0]           instr,
    input  logic [31:0]           v0,
    input  logic                  arm,
    input  logic [31:0]           trigPc,
    input  logic                  trigEn,
    input  logic [DEPTH_LOG2-1:0] rdIdx,
    output logic [31:0]           rdPc,
    output logic [31:0]           rdInstr,
    output logic [31:0]           rdV0,
    output logic [15:0]           rdStamp,
    output logic                  rdValid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  triggered,
    output logic                  timedOut,
    output logic                  done
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
    localparam int unsigned TMO_W   = (TIMEOUT > 32'd2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned ENTRY_W = 32 + 32 + 32 + 16;

    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
    // Only meaningful when TIMEOUT != 0; the comparison is gated on that.
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 32'd1);
    // Only meaningful when POST_TRIG != 0; POST is never entered otherwise.
    localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_TRIG - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DEPTH_LOG2-1:0]   post_q, post_d;
    logic [15:0]             stamp_q, stamp_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    triggered_q, triggered_d;
    logic                    timed_out_q, timed_out_d;
    logic                    done_q, done_d;
    logic                    wr_en_s;

    logic [ENTRY_W-1:0]      mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   rd_addr_s;
    logic                    rd_hit_s;
    logic [31:0]             rd_pc_q, rd_instr_q, rd_v0_q;
    logic [15:0]             rd_stamp_q;
    logic                    rd_valid_q;

    // Control state and counters register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {DEPTH_LOG2{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            post_q      <= {DEPTH_LOG2{1'b0}};
            stamp_q     <= 16'd0;
            tmo_q       <= {TMO_W{1'b0}};
            triggered_q <= 1'b0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            stamp_q     <= stamp_d;
            tmo_q       <= tmo_d;
            triggered_q <= triggered_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: arm restarts from any state; otherwise sample and decide when to freeze.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        stamp_d     = stamp_q;
        tmo_d       = tmo_q;
        triggered_d = triggered_q;
        timed_out_d = timed_out_q;
        wr_en_s     = 1'b0;

        if (arm) begin
            // The arm cycle itself never records a sample.
            state_d     = ST_ARMED;
            wr_ptr_d    = {DEPTH_LOG2{1'b0}};
            count_d     = {CNT_W{1'b0}};
            post_d      = {DEPTH_LOG2{1'b0}};
            stamp_d     = 16'd0;
            tmo_d       = {TMO_W{1'b0}};
            triggered_d = 1'b0;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (cpuEn) begin
                        wr_en_s = 1'b1;
                        // A trigger beats a timeout landing on the same sample.
                        if (trigEn && (pc == trigPc)) begin
                            triggered_d = 1'b1;
                            if (POST_TRIG == 32'd0) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_POST;
                                post_d  = {DEPTH_LOG2{1'b0}};
                            end
                        end else if ((TIMEOUT != 32'd0) && (tmo_q == TMO_LAST)) begin
                            state_d     = ST_DONE;
                            timed_out_d = 1'b1;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                ST_POST: begin
                    if (cpuEn) begin
                        wr_en_s = 1'b1;
                        post_d  = post_q + DEPTH_LOG2'(1);
                        if (post_q == POST_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Every recorded sample advances the write pointer, fill count and stamp.
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                count_d  = (count_q == CNT_FULL) ? count_q : (count_q + CNT_W'(1));
                stamp_d  = stamp_q + 16'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
                count_d  = count_q;
                stamp_d  = stamp_q;
            end
        end

        done_d = (state_d == ST_DONE);
    end

    // Trace storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {pc, instr, v0, stamp_q};
        end
    end

    // Oldest entry sits count positions behind the write pointer (mod DEPTH);
    // when full the low bits of count are zero, so that is wr_ptr itself.
    assign rd_addr_s = wr_ptr_q - count_q[DEPTH_LOG2-1:0] + rdIdx;
    assign rd_hit_s  = done_q && ({1'b0, rdIdx} < count_q);

    // Registered readout; data holds its last value when the index is not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pc_q    <= 32'd0;
            rd_instr_q <= 32'd0;
            rd_v0_q    <= 32'd0;
            rd_stamp_q <= 16'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_hit_s;
            if (rd_hit_s) begin
                {rd_pc_q, rd_instr_q, rd_v0_q, rd_stamp_q} <= mem_q[rd_addr_s];
            end
        end
    end

    assign rdPc      = rd_pc_q;
    assign rdInstr   = rd_instr_q;
    assign rdV0      = rd_v0_q;
    assign rdStamp   = rd_stamp_q;
    assign rdValid   = rd_valid_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign timedOut  = timed_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_sm_trace_buffer
//
// Scoreboard bench for sm_trace_buffer with default parameters (DEPTH=16,
// POST_TRIG=4, TIMEOUT=120). Every driven cycle pushes the expected readout
// (due one cycle later) and the expected status (due after the edge) into a
// queue; an independent monitor pops and compares them on the falling edge.
// The reference model is a list of captured records trimmed to the last DEPTH.
// -----------------------------------------------------------------------------
module tb_sm_trace_buffer;

    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;
    localparam int TIMEOUT   = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuEn;
    logic [31:0] pc, instr, v0;
    logic        arm;
    logic [31:0] trigPc;
    logic        trigEn;
    logic [3:0]  rdIdx;
    logic [31:0] rdPc, rdInstr, rdV0;
    logic [15:0] rdStamp;
    logic        rdValid;
    logic [4:0]  count;
    logic        triggered, timedOut, done;

    always #5 clk = ~clk;

    sm_trace_buffer dut (
        .clk(clk), .rst(rst), .cpuEn(cpuEn), .pc(pc), .instr(instr), .v0(v0),
        .arm(arm), .trigPc(trigPc), .trigEn(trigEn), .rdIdx(rdIdx),
        .rdPc(rdPc), .rdInstr(rdInstr), .rdV0(rdV0), .rdStamp(rdStamp),
        .rdValid(rdValid), .count(count), .triggered(triggered),
        .timedOut(timedOut), .done(done)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] v0;
        logic [15:0] stamp;
    } rec_t;

    typedef struct {
        int   due;
        bit   is_rd;
        bit   valid;
        rec_t r;
        int   cnt;
        bit   trig;
        bit   to;
        bit   dn;
    } exp_t;

    // Reference model state
    rec_t        cap[$];
    logic [15:0] m_stamp;
    int          m_tmo, m_post;
    bit          m_run, m_in_post, m_trig, m_to, m_done;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: compares every expectation that has come due.
    exp_t e_mon;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e_mon = exp_q.pop_front();
            if (e_mon.due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL late_expectation at cycle %0d: got due %0d expected %0d", cyc, e_mon.due, cyc);
            end else if (e_mon.is_rd) begin
                check("rdValid", 32'(rdValid), 32'(e_mon.valid));
                if (e_mon.valid) begin
                    check("rdPc", rdPc, e_mon.r.pc);
                    check("rdInstr", rdInstr, e_mon.r.instr);
                    check("rdV0", rdV0, e_mon.r.v0);
                    check("rdStamp", 32'(rdStamp), 32'(e_mon.r.stamp));
                end
            end else begin
                check("count", 32'(count), 32'(e_mon.cnt));
                check("triggered", 32'(triggered), 32'(e_mon.trig));
                check("timedOut", 32'(timedOut), 32'(e_mon.to));
                check("done", 32'(done), 32'(e_mon.dn));
            end
        end
    end

    task automatic model_reset();
        cap.delete();
        m_stamp = 16'd0; m_tmo = 0; m_post = 0;
        m_run = 1'b0; m_in_post = 1'b0; m_trig = 1'b0; m_to = 1'b0; m_done = 1'b0;
    endtask

    // One clock edge of the behavioural model given this cycle's inputs.
    task automatic model_step(input bit a, input bit en, input rec_t s, input bit te, input logic [31:0] tp);
        rec_t w;
        if (a) begin
            model_reset();
            m_run = 1'b1;
        end else if (m_run && en) begin
            w = s;
            w.stamp = m_stamp;
            cap.push_back(w);
            if (cap.size() > DEPTH) void'(cap.pop_front());
            m_stamp = m_stamp + 16'd1;
            if (m_in_post) begin
                m_post++;
                if (m_post == POST_TRIG) begin m_run = 1'b0; m_done = 1'b1; end
            end else if (te && s.pc == tp) begin
                m_trig = 1'b1;
                if (POST_TRIG == 0) begin m_run = 1'b0; m_done = 1'b1; end
                else begin m_in_post = 1'b1; m_post = 0; end
            end else begin
                m_tmo++;
                if (TIMEOUT != 0 && m_tmo == TIMEOUT) begin
                    m_run = 1'b0; m_done = 1'b1; m_to = 1'b1;
                end
            end
        end
    endtask

    task automatic push_status();
        exp_t e;
        e.due = cyc; e.is_rd = 1'b0; e.valid = 1'b0;
        e.r = '{32'd0, 32'd0, 32'd0, 16'd0};
        e.cnt = cap.size(); e.trig = m_trig; e.to = m_to; e.dn = m_done;
        exp_q.push_back(e);
    endtask

    task automatic push_read(input int due, input logic [3:0] idx);
        exp_t e;
        e.due = due; e.is_rd = 1'b1;
        e.valid = m_done && (int'(idx) < cap.size());
        e.r = e.valid ? cap[idx] : '{32'd0, 32'd0, 32'd0, 16'd0};
        e.cnt = 0; e.trig = 1'b0; e.to = 1'b0; e.dn = 1'b0;
        exp_q.push_back(e);
    endtask

    // Drive one cycle (called #1 after a rising edge) and queue its expectations.
    task automatic drive(input bit a, input bit en, input logic [31:0] p, input bit te,
                         input logic [31:0] tp, input logic [3:0] idx);
        rec_t s;
        s.pc = p; s.instr = $urandom(); s.v0 = $urandom(); s.stamp = 16'd0;
        arm = a; cpuEn = en; pc = p; instr = s.instr; v0 = s.v0;
        trigEn = te; trigPc = tp; rdIdx = idx;
        push_read(cyc + 1, idx);
        model_step(a, en, s, te, tp);
        @(posedge clk); #1;
        push_status();
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; arm = 1'b0; cpuEn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("rdPc_after_rst", rdPc, 32'd0);
        check("rdStamp_after_rst", 32'(rdStamp), 32'd0);
        rst = 1'b0;
        push_status();
        push_read(cyc, 4'd0);
    endtask

    // Arm, then feed a sequential pc stream 0..n-1 with cpuEn=1.
    task automatic seq_run(input bit te, input logic [31:0] tp, input int n);
        drive(1'b1, 1'b0, 32'd0, te, tp, 4'($urandom_range(0, 15)));
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b1, 32'(k), te, tp, 4'($urandom_range(0, 15)));
    endtask

    // Read every index while random cpuEn/pc traffic (with live trigger) continues.
    task automatic sweep();
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 40)), 1'b1,
                  32'($urandom_range(0, 40)), 4'(i));
    endtask

    bit          r_arm, r_te;
    logic [31:0] r_tp;

    initial begin
        rst = 1'b1; arm = 1'b0; cpuEn = 1'b0; pc = 32'd0; instr = 32'd0; v0 = 32'd0;
        trigPc = 32'd0; trigEn = 1'b0; rdIdx = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdPc", rdPc, 32'd0);
        check("rst_rdInstr", rdInstr, 32'd0);
        check("rst_rdV0", rdV0, 32'd0);
        check("rst_rdValid", 32'(rdValid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        push_status();

        // Trigger at pc 5: DONE after pc 9, ten entries.
        seq_run(1'b1, 32'd5, 12);
        sweep();

        // Trigger at pc 30: buffer wraps, window pc 19..34.
        seq_run(1'b1, 32'd30, 40);
        sweep();

        // No trigger: timeout after 120 samples, last entry pc 119.
        seq_run(1'b0, 32'd0, 125);
        sweep();

        // cpuEn alternating; pc 7 first appears with cpuEn=0 and must be ignored.
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'd7, 4'd0);
        for (int k = 0; k < 26; k++)
            drive(1'b0, (k < 12) ? (k % 2 == 0) : 1'b1, 32'(k % 10), 1'b1, 32'd7,
                  4'($urandom_range(0, 15)));
        sweep();

        // arm mid-POST coincident with a trigger match, then arm during DONE.
        seq_run(1'b1, 32'd3, 6);
        drive(1'b1, 1'b1, 32'd3, 1'b1, 32'd3, 4'd0);
        for (int k = 10; k < 22; k++)
            drive(1'b0, 1'b1, 32'(k), 1'b1, 32'd12, 4'($urandom_range(0, 15)));
        drive(1'b1, 1'b1, 32'd12, 1'b1, 32'd12, 4'd0);
        for (int k = 0; k < 10; k++)
            drive(1'b0, 1'b1, 32'(k + 50), 1'b1, 32'd55, 4'($urandom_range(0, 15)));
        sweep();

        // Reset mid-POST, idle traffic without arm, then a clean restart.
        seq_run(1'b1, 32'd2, 5);
        do_reset();
        for (int k = 0; k < 4; k++)
            drive(1'b0, 1'b1, 32'(k), 1'b1, 32'd1, 4'($urandom_range(0, 15)));
        seq_run(1'b1, 32'd5, 12);
        sweep();

        // Randomised traffic with occasional re-arm.
        r_te = 1'b1; r_tp = 32'd5;
        for (int k = 0; k < 800; k++) begin
            r_arm = ($urandom_range(0, 39) == 0);
            if (r_arm) begin
                r_te = ($urandom_range(0, 3) != 0);
                r_tp = 32'($urandom_range(0, 23));
            end
            drive(r_arm, ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 23)), r_te, r_tp,
                  4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
